pipe_ctrl: RTL and testbench

//  Pipeline sequencer between the EX stage and the PC/IF/ID/EX pipeline registers.
//  - Takes EX jump requests (jump_en/jump_addr) and hold requests from EX and from the memory bus.
//  - Drives PC redirect, per-stage hold and flush controls.
//  - Defers a redirect that arrives while the bus is stalled, then issues it.
//  - Runs a multi-cycle flush window and a hold watchdog.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/hold_watchdog.sv | 26 ++
 rtl/pipe_ctrl.sv | 98 +++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and hold-vector constants for the pipeline sequencer.
package pipe_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_e;
    localparam int HOLD_PC   = 0;
    localparam int HOLD_IFID = 1;
    localparam int HOLD_IDEX = 2;
    localparam logic [2:0] HOLD_ALL   = 3'b111;
    localparam logic [2:0] HOLD_FRONT = 3'b011;
endpackage

// File: rtl/hold_watchdog.sv
// hold_watchdog: counts consecutive held cycles (16-bit, saturating) and raises a sticky error at HOLD_TIMEOUT.
module hold_watchdog #(
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_any_i,
    output logic err_o
);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    always_comb begin
        cnt_d = hold_any_i ? (&cnt_q ? cnt_q : cnt_q + 16'd1) : 16'd0;
        err_d = err_q | (cnt_d == 16'(HOLD_TIMEOUT));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: EX-to-pipeline sequencer issuing PC redirects, per-stage holds, flush windows and a hold watchdog.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_o,
    output logic        flush_o,
    output logic        err_timeout_o
);
    localparam state_e     ISSUE_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        hold_o      = '0;
        flush_o     = 1'b0;
        case (state_q)
            RUN: begin
                if (jump_en_i && !hold_bus_i) begin
                    jump_en_o   = 1'b1;
                    jump_addr_o = jump_addr_i;
                    flush_o     = 1'b1;
                    state_d     = ISSUE_NEXT;
                    cnt_d       = FLUSH_INIT;
                end else if (hold_bus_i) begin
                    hold_o = HOLD_ALL;
                    if (jump_en_i) begin
                        pend_d  = jump_addr_i;
                        state_d = PEND;
                    end
                end else if (hold_ex_i) begin
                    hold_o = HOLD_FRONT;
                end
            end
            PEND: begin
                if (hold_bus_i) begin
                    hold_o = HOLD_ALL;
                end else begin
                    jump_en_o   = 1'b1;
                    jump_addr_o = pend_q;
                    flush_o     = 1'b1;
                    state_d     = ISSUE_NEXT;
                    cnt_d       = FLUSH_INIT;
                end
            end
            FLUSH: begin
                flush_o = 1'b1;
                if (hold_bus_i) begin
                    hold_o = HOLD_ALL;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q <= 4'd1) ? RUN : FLUSH;
                end
            end
            default: state_d = RUN;
        endcase
        // outputs must read zero for the whole reset window, not just after the first edge
        if (!rst_n) begin
            jump_en_o   = 1'b0;
            jump_addr_o = '0;
            hold_o      = '0;
            flush_o     = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end
    hold_watchdog #(.HOLD_TIMEOUT(HOLD_TIMEOUT)) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_any_i(|hold_o),
        .err_o     (err_timeout_o)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenario tests for pipe_ctrl with hand-computed expected output vectors.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_ex_i = 1'b0;
    logic        hold_bus_i = 1'b0;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_o;
    logic        flush_o;
    logic        err_timeout_o;
    int errors = 0;
    int checks = 0;
    logic [36:0] outs;
    logic [36:0] exp_o;
    assign outs = {jump_en_o, jump_addr_o, hold_o, flush_o};

    pipe_ctrl #(.FLUSH_CYCLES(2), .HOLD_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_ex_i    (hold_ex_i),
        .hold_bus_i   (hold_bus_i),
        .jump_en_o    (jump_en_o),
        .jump_addr_o  (jump_addr_o),
        .hold_o       (hold_o),
        .flush_o      (flush_o),
        .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic j, input logic [31:0] a, input logic ex, input logic bus);
        jump_en_i   = j;
        jump_addr_i = a;
        hold_ex_i   = ex;
        hold_bus_i  = bus;
    endtask

    task automatic test_reset;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL reset_outs: got %h exp %h", outs, 37'd0); end
        checks++;
        if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_timeout_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL reset_idle: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_jump;
        @(negedge clk);
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        #1;
        exp_o = {1'b1, 32'h0000_0100, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL jump_issue: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        exp_o = {1'b0, 32'h0, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL jump_flush1: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL jump_flush_end: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_pend;
        @(negedge clk);
        drive(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        #1;
        exp_o = {1'b0, 32'h0, 3'b111, 1'b0};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL pend_c1: got %h exp %h", outs, exp_o); end
        // new jump and EX hold during PEND must not disturb the latched target
        @(negedge clk);
        drive(1'b1, 32'h0000_2BAD, 1'b1, 1'b1);
        #1;
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL pend_c2: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL pend_c3: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        exp_o = {1'b1, 32'h0000_0200, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL pend_issue: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        #1;
        exp_o = {1'b0, 32'h0, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL pend_flush1: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL pend_flush_end: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_hold_ex;
        exp_o = {1'b0, 32'h0, 3'b011, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            checks++;
            if (outs !== exp_o) begin errors++; $display("FAIL hold_ex_c%0d: got %h exp %h", i, outs, exp_o); end
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL hold_ex_release: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_flush_ignore;
        @(negedge clk);
        drive(1'b1, 32'h0000_0500, 1'b0, 1'b0);
        #1;
        exp_o = {1'b1, 32'h0000_0500, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL fign_issue: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        drive(1'b1, 32'h0000_0300, 1'b0, 1'b0);
        #1;
        exp_o = {1'b0, 32'h0, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL fign_ignored: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL fign_end: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_flush_stall;
        @(negedge clk);
        drive(1'b1, 32'h0000_0600, 1'b0, 1'b0);
        #1;
        exp_o = {1'b1, 32'h0000_0600, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL fstall_issue: got %h exp %h", outs, exp_o); end
        exp_o = {1'b0, 32'h0, 3'b111, 1'b1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checks++;
            if (outs !== exp_o) begin errors++; $display("FAIL fstall_hold%0d: got %h exp %h", i, outs, exp_o); end
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        exp_o = {1'b0, 32'h0, 3'b000, 1'b1};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL fstall_resume: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL fstall_end: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (err_timeout_o !== (i >= 4)) begin
                errors++;
                $display("FAIL timeout_c%0d: got %b exp %b", i, err_timeout_o, (i >= 4));
            end
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (err_timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b exp 1", err_timeout_o); end
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL timeout_idle: got %h exp %h", outs, 37'd0); end
    endtask

    task automatic test_reset_pend;
        @(negedge clk);
        drive(1'b1, 32'h0000_0400, 1'b0, 1'b1);
        #1;
        exp_o = {1'b0, 32'h0, 3'b111, 1'b0};
        checks++;
        if (outs !== exp_o) begin errors++; $display("FAIL rpend_enter: got %h exp %h", outs, exp_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 37'd0) begin errors++; $display("FAIL rpend_async: got %h exp %h", outs, 37'd0); end
        checks++;
        if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL rpend_err_clear: got %b exp 0", err_timeout_o); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (outs !== 37'd0) begin errors++; $display("FAIL rpend_after%0d: got %h exp %h", i, outs, 37'd0); end
        end
    endtask

    initial begin
        test_reset;
        test_jump;
        test_pend;
        test_hold_ex;
        test_flush_ignore;
        test_flush_stall;
        checks++;
        if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL err_early: got %b exp 0", err_timeout_o); end
        test_timeout;
        test_reset_pend;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish exp finish");
        $fatal(1);
    end
endmodule
